silife_matrix_wb_master: RTL and testbench

SILIFE_MATRIX_WB_MASTER -- requirements
Module: silife_matrix_wb_master

---
 rtl/silife_pkg.sv | 20 ++
 rtl/silife_matrix_wb_master_if.sv | 25 ++
 rtl/silife_wb_watchdog.sv | 31 +++
 rtl/silife_matrix_wb_master.sv | 166 ++++++++++++++++
 tb/tb_silife_matrix_wb_master.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/silife_pkg.sv
// Shared definitions for the silife matrix Wishbone master.
//   ROW_STRIDE : byte distance between consecutive matrix rows on the bus
//   WB_*W      : Wishbone address / data / select widths
//   state_t    : transfer controller states
package silife_pkg;

  localparam int unsigned ROW_STRIDE = 4;
  localparam int unsigned WB_AW      = 32;
  localparam int unsigned WB_DW      = 32;
  localparam int unsigned WB_SW      = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    BUS   = 3'd2,
    PUSH  = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/silife_matrix_wb_master_if.sv
// Wishbone initiator bundle.
//   o_wb_cyc/stb/we/addr/data/sel : driven by the master
//   i_wb_ack/data                 : driven by the responder
interface silife_matrix_wb_master_if;
  import silife_pkg::*;

  logic             o_wb_cyc;
  logic             o_wb_stb;
  logic             o_wb_we;
  logic [WB_AW-1:0] o_wb_addr;
  logic [WB_DW-1:0] o_wb_data;
  logic [WB_SW-1:0] o_wb_sel;
  logic             i_wb_ack;
  logic [WB_DW-1:0] i_wb_data;

  modport master (
    output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
    input  i_wb_ack, i_wb_data
  );

  modport slave (
    input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
    output i_wb_ack, i_wb_data
  );
endinterface

// File: rtl/silife_wb_watchdog.sv
// Counts cycles while enabled; flags the cycle on which TIMEOUT is reached.
//   clk, reset  : clock, synchronous active-high reset
//   i_clear     : synchronous counter clear
//   i_enable    : count this cycle
//   o_expired_c : high during the TIMEOUT-th enabled cycle (combinational)
module silife_wb_watchdog #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired_c
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [CW-1:0] r_cnt;

  // Saturating cycle counter
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && (r_cnt != CW'(TIMEOUT))) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_expired_c = i_enable && (r_cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/silife_matrix_wb_master.sv
// Moves a WIDTH x HEIGHT cell matrix between a row stream and Wishbone memory,
// one 32-bit word per row at BASE_ADDR + ROW_STRIDE*row.
//   clk, reset          : clock, synchronous active-high reset
//   start, dir          : begin transfer (dir 0 = dump rows, 1 = load rows)
//   busy, done, error   : status; done/error are one-cycle pulses
//   wr_data/valid/ready : row stream in (load)
//   rd_data/valid/ready : row stream out (dump)
//   wb                  : Wishbone initiator
module silife_matrix_wb_master
  import silife_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned HEIGHT    = 8,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             dir,
  output logic             busy,
  output logic             done,
  output logic             error,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  silife_matrix_wb_master_if.master wb
);

  localparam int unsigned RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  state_t           r_state, w_state_n;
  logic [RW-1:0]    r_row, w_row_n;
  logic             r_dir, w_dir_n;
  logic [WIDTH-1:0] r_rd_data, w_rd_data_n;
  logic [31:0]      r_wdata, w_wdata_n;
  logic             w_err_n;
  logic             w_last;
  logic             w_expired;
  logic             w_unused_rdata;

  logic        r_busy, r_done, r_error, r_wr_ready, r_rd_valid, r_cyc, r_we;
  logic [31:0] r_addr;

  assign w_last         = (r_row == RW'(HEIGHT - 1));
  assign w_unused_rdata = ^wb.i_wb_data;

  silife_wb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk         (clk),
    .reset       (reset),
    .i_clear     (r_state != BUS),
    .i_enable    (r_state == BUS),
    .o_expired_c (w_expired)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_n;
  end

  // Next state and datapath updates; ack is only looked at in BUS because a
  // registered-ack responder repeats it in the cycle after cyc drops.
  always_comb begin
    w_state_n   = r_state;
    w_row_n     = r_row;
    w_dir_n     = r_dir;
    w_rd_data_n = r_rd_data;
    w_wdata_n   = r_wdata;
    w_err_n     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_dir_n   = dir;
          w_row_n   = '0;
          w_wdata_n = '0;
          w_state_n = dir ? FETCH : BUS;
        end
      end
      FETCH: begin
        if (wr_valid) begin
          w_wdata_n = 32'(wr_data);
          w_state_n = BUS;
        end
      end
      BUS: begin
        if (wb.i_wb_ack) begin
          if (!r_dir) begin
            w_rd_data_n = wb.i_wb_data[WIDTH-1:0];
            w_state_n   = PUSH;
          end else if (w_last) begin
            w_state_n = DONE;
          end else begin
            w_row_n   = r_row + RW'(1);
            w_state_n = FETCH;
          end
        end else if (w_expired) begin
          w_err_n   = 1'b1;
          w_state_n = IDLE;
        end
      end
      PUSH: begin
        if (rd_ready) begin
          if (w_last) begin
            w_state_n = DONE;
          end else begin
            w_row_n   = r_row + RW'(1);
            w_state_n = BUS;
          end
        end
      end
      DONE:    w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase
  end

  // Registered datapath and outputs, aligned with the state they belong to
  always_ff @(posedge clk) begin
    if (reset) begin
      r_row      <= '0;
      r_dir      <= 1'b0;
      r_rd_data  <= '0;
      r_wdata    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_wr_ready <= 1'b0;
      r_rd_valid <= 1'b0;
      r_cyc      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
    end else begin
      r_row      <= w_row_n;
      r_dir      <= w_dir_n;
      r_rd_data  <= w_rd_data_n;
      r_wdata    <= w_wdata_n;
      r_busy     <= (w_state_n != IDLE);
      r_done     <= (w_state_n == DONE);
      r_error    <= w_err_n;
      r_wr_ready <= (w_state_n == FETCH);
      r_rd_valid <= (w_state_n == PUSH);
      r_cyc      <= (w_state_n == BUS);
      r_we       <= (w_state_n == BUS) && w_dir_n;
      if (w_state_n == BUS) begin
        r_addr <= BASE_ADDR + 32'(ROW_STRIDE) * 32'(w_row_n);
      end
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign error        = r_error;
  assign wr_ready     = r_wr_ready;
  assign rd_valid     = r_rd_valid;
  assign rd_data      = r_rd_data;
  assign wb.o_wb_cyc  = r_cyc;
  assign wb.o_wb_stb  = r_cyc;
  assign wb.o_wb_we   = r_we;
  assign wb.o_wb_addr = r_addr;
  assign wb.o_wb_data = r_wdata;
  assign wb.o_wb_sel  = 4'b1111;

endmodule

// File: tb/tb_silife_matrix_wb_master.sv
// Directed bench for silife_matrix_wb_master with a registered-ack responder.
module tb_silife_matrix_wb_master;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic       clk = 1'b0;
  logic       reset, start, dir, busy, done, error;
  logic       wr_valid, wr_ready, rd_valid, rd_ready;
  logic [7:0] wr_data, rd_data;

  silife_matrix_wb_master_if wb();

  silife_matrix_wb_master #(
    .WIDTH(8), .HEIGHT(8), .BASE_ADDR(BASE), .TIMEOUT(15)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .dir(dir),
    .busy(busy), .done(done), .error(error),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .wb(wb)
  );

  always #5 clk = ~clk;

  // Responder: ack registered from cyc&&stb (repeats once after cyc drops)
  logic       ack_en;
  logic [7:0] mem [8];
  always @(posedge clk) begin
    wb.i_wb_ack  <= ack_en && wb.o_wb_cyc && wb.o_wb_stb;
    wb.i_wb_data <= {24'h0, mem[3'((wb.o_wb_addr - BASE) >> 2)]};
  end

  // Transaction log: one entry per stb rising edge
  int          cyc_cnt = 0;
  int          n_tx = 0;
  logic        stb_q = 1'b0;
  logic [31:0] log_addr [64];
  logic [31:0] log_data [64];
  logic        log_we   [64];
  int          log_t    [64];
  always @(posedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    stb_q   <= wb.o_wb_stb;
    if (wb.o_wb_stb === 1'b1 && stb_q !== 1'b1 && n_tx < 64) begin
      log_addr[n_tx] <= wb.o_wb_addr;
      log_data[n_tx] <= wb.o_wb_data;
      log_we[n_tx]   <= wb.o_wb_we;
      log_t[n_tx]    <= cyc_cnt;
      n_tx           <= n_tx + 1;
    end
  end

  int   n_cmp = 0, n_fail = 0;
  int   n_done, n_err, rows_got, stall_row, stall_len, stall_cnt, done_t;
  int   base, base2, n_stb, n_cyc;
  bit   pulse_en, pulsed;
  logic hs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    n_done = 0; n_err = 0; rows_got = 0; stall_cnt = 0; pulsed = 0; done_t = -1;
  endtask

  task automatic start_xfer(input logic d);
    @(negedge clk);
    start = 1'b1; dir = d;
    @(posedge clk); #1;
    start = 1'b0; dir = 1'b0;
  endtask

  // One cycle: observe at negedge, drive rd_ready/start, advance wr_data on handshake
  task automatic tick();
    @(negedge clk);
    if (done)  begin n_done++; done_t = cyc_cnt; end
    if (error) n_err++;
    hs = wr_ready && wr_valid;
    if (rd_valid) begin
      if (rows_got == stall_row && stall_cnt < stall_len) begin
        rd_ready = 1'b0;
        stall_cnt++;
        chk("stall_hold", {24'h0, rd_data}, {24'h0, 8'hA0 + 8'(stall_row)});
        chk("stall_no_stb", {31'h0, wb.o_wb_stb}, 32'h0);
      end else begin
        rd_ready = 1'b1;
        chk("rd_order", {24'h0, rd_data}, {24'h0, 8'hA0 + 8'(rows_got)});
        rows_got++;
      end
    end else begin
      rd_ready = 1'b1;
    end
    if (pulse_en && !pulsed && wb.o_wb_stb && wb.o_wb_addr == BASE + 32'd8) begin
      start = 1'b1; dir = 1'b1; pulsed = 1'b1;
    end
    @(posedge clk); #1;
    start = 1'b0; dir = 1'b0;
    if (hs) wr_data = wr_data + 8'd1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},     {31'h0, busy},         32'h0);
    chk({tag, "_done"},     {31'h0, done},         32'h0);
    chk({tag, "_error"},    {31'h0, error},        32'h0);
    chk({tag, "_wr_ready"}, {31'h0, wr_ready},     32'h0);
    chk({tag, "_rd_valid"}, {31'h0, rd_valid},     32'h0);
    chk({tag, "_cyc"},      {31'h0, wb.o_wb_cyc},  32'h0);
    chk({tag, "_stb"},      {31'h0, wb.o_wb_stb},  32'h0);
    chk({tag, "_we"},       {31'h0, wb.o_wb_we},   32'h0);
    chk({tag, "_addr"},     wb.o_wb_addr,          32'h0);
    chk({tag, "_wdata"},    wb.o_wb_data,          32'h0);
    chk({tag, "_rd_data"},  {24'h0, rd_data},      32'h0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; dir = 1'b0; wr_valid = 1'b0; wr_data = 8'h0;
    rd_ready = 1'b1; ack_en = 1'b1; stall_row = -1; stall_len = 0; pulse_en = 0;
    for (int i = 0; i < 8; i++) mem[i] = 8'hA0 + 8'(i);
    clear_stats();

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    chk("reset_sel", {28'h0, wb.o_wb_sel}, 32'hF);
    reset = 1'b0;

    // Load 0x01..0x08 with wr_valid held high
    base = n_tx; wr_data = 8'h01; wr_valid = 1'b1; clear_stats();
    start_xfer(1'b1);
    for (int c = 0; c < 200 && n_done == 0 && n_err == 0; c++) tick();
    wr_valid = 1'b0;
    chk("load_done_cnt", 32'(n_done), 32'd1);
    chk("load_err_cnt", 32'(n_err), 32'd0);
    chk("load_tx_cnt", 32'(n_tx - base), 32'd8);
    chk("load_handshakes", {24'h0, wr_data}, 32'h9);
    for (int i = 0; i < 8; i++) begin
      chk("load_addr", log_addr[base + i], BASE + 32'(4 * i));
      chk("load_we", {31'h0, log_we[base + i]}, 32'h1);
      chk("load_data", log_data[base + i], 32'(i + 1));
    end
    for (int i = 0; i < 7; i++)
      chk("load_rate", 32'(log_t[base + i + 1] - log_t[base + i]), 32'd3);
    chk("load_done_lat", 32'(done_t - log_t[base + 7]), 32'd2);
    tick();
    chk("load_idle_busy", {31'h0, busy}, 32'h0);
    chk("load_idle_done", {31'h0, done}, 32'h0);

    // Dump with a 5-cycle rd_ready stall at row 3
    base = n_tx; stall_row = 3; stall_len = 5; clear_stats();
    start_xfer(1'b0);
    for (int c = 0; c < 300 && n_done == 0 && n_err == 0; c++) tick();
    stall_row = -1;
    chk("dump_done_cnt", 32'(n_done), 32'd1);
    chk("dump_rows", 32'(rows_got), 32'd8);
    chk("dump_stall_len", 32'(stall_cnt), 32'd5);
    chk("dump_stb_edges", 32'(n_tx - base), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk("dump_addr", log_addr[base + i], BASE + 32'(4 * i));
      chk("dump_we", {31'h0, log_we[base + i]}, 32'h0);
      chk("dump_wdata", log_data[base + i], 32'h0);
    end
    for (int i = 0; i < 3; i++)
      chk("dump_rate", 32'(log_t[base + i + 1] - log_t[base + i]), 32'd3);
    chk("dump_stall_gap", 32'(log_t[base + 4] - log_t[base + 3]), 32'd8);
    chk("dump_done_lat", 32'(done_t - log_t[base + 7]), 32'd3);

    // Dump with a stray start pulse at row 2
    base = n_tx; pulse_en = 1; clear_stats();
    start_xfer(1'b0);
    for (int c = 0; c < 300 && n_done == 0 && n_err == 0; c++) tick();
    pulse_en = 0;
    chk("restart_pulsed", {31'h0, pulsed}, 32'h1);
    chk("restart_done_cnt", 32'(n_done), 32'd1);
    chk("restart_rows", 32'(rows_got), 32'd8);
    chk("restart_tx_cnt", 32'(n_tx - base), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk("restart_addr", log_addr[base + i], BASE + 32'(4 * i));
      chk("restart_we", {31'h0, log_we[base + i]}, 32'h0);
    end

    // Timeout: responder never acks
    base = n_tx; ack_en = 1'b0; clear_stats(); n_stb = 0; n_cyc = 0;
    start_xfer(1'b0);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (wb.o_wb_stb) n_stb++;
      if (wb.o_wb_cyc) n_cyc++;
      if (done) n_done++;
      if (error) begin
        n_err++;
        chk("to_busy_at_err", {31'h0, busy}, 32'h0);
      end
    end
    ack_en = 1'b1;
    chk("to_stb_cycles", 32'(n_stb), 32'd15);
    chk("to_cyc_cycles", 32'(n_cyc), 32'd15);
    chk("to_err_cnt", 32'(n_err), 32'd1);
    chk("to_done_cnt", 32'(n_done), 32'd0);
    chk("to_busy_end", {31'h0, busy}, 32'h0);
    chk("to_tx_cnt", 32'(n_tx - base), 32'd1);

    // Reset during row 4 of a load, then dump restarts at row 0
    wr_data = 8'h01; wr_valid = 1'b1; clear_stats();
    start_xfer(1'b1);
    for (int c = 0; c < 200 && !(wb.o_wb_stb === 1'b1 && wb.o_wb_addr === BASE + 32'd16); c++)
      tick();
    chk("rst_reached_row4", {31'h0, wb.o_wb_stb}, 32'h1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_all_zero("midrst");
    reset = 1'b0; wr_valid = 1'b0;
    base2 = n_tx; clear_stats();
    start_xfer(1'b0);
    for (int c = 0; c < 300 && n_done == 0 && n_err == 0; c++) tick();
    chk("post_rst_done_cnt", 32'(n_done), 32'd1);
    chk("post_rst_err_cnt", 32'(n_err), 32'd0);
    chk("post_rst_rows", 32'(rows_got), 32'd8);
    chk("post_rst_first_addr", log_addr[base2], BASE);
    chk("post_rst_first_we", {31'h0, log_we[base2]}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
